// File: rtl/serial_link_xcvr.sv
// 8N1 serial transceiver between the Nios II PIO ports and the inter-board wire.
// TX holding register + shift FSM, RX synchroniser + mid-bit sampling FSM.
module serial_link_xcvr #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned DATA_W       = 8
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic [DATA_W-1:0] bus_out,
    input  logic              load,
    input  logic              trans_en,
    output logic              char_sent,
    output logic              tx_busy,
    output logic              tx_serial,
    input  logic              rx_serial,
    output logic [DATA_W-1:0] bus_in,
    output logic              char_rec,
    output logic              frame_err
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [CNT_W-1:0] CNT_HALF     = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_W-1:0] BIT_LAST     = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } xfer_state_e;

    // ---------------------------------------------------------------- TX
    xfer_state_e       tx_state, tx_state_nx;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_nx;
    logic [BIT_W-1:0]  tx_bit, tx_bit_nx;
    logic [DATA_W-1:0] tx_shift, tx_shift_nx;
    logic [DATA_W-1:0] hold_data, hold_data_nx;
    logic              hold_valid, hold_valid_nx;
    logic              load_q;
    logic              tx_serial_nx, tx_busy_nx, char_sent_nx;
    logic              load_rise;
    logic              tx_cnt_last;

    assign load_rise   = load & ~load_q;
    assign tx_cnt_last = (tx_cnt == CNT_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            tx_state   <= ST_IDLE;
            tx_cnt     <= '0;
            tx_bit     <= '0;
            tx_shift   <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            load_q     <= 1'b0;
            tx_serial  <= 1'b1;
            tx_busy    <= 1'b0;
            char_sent  <= 1'b0;
        end else begin
            tx_state   <= tx_state_nx;
            tx_cnt     <= tx_cnt_nx;
            tx_bit     <= tx_bit_nx;
            tx_shift   <= tx_shift_nx;
            hold_data  <= hold_data_nx;
            hold_valid <= hold_valid_nx;
            load_q     <= load;
            tx_serial  <= tx_serial_nx;
            tx_busy    <= tx_busy_nx;
            char_sent  <= char_sent_nx;
        end
    end

    // Line value is registered one bit ahead: each transition loads the level of the next bit.
    always_comb begin
        tx_state_nx   = tx_state;
        tx_cnt_nx     = tx_cnt;
        tx_bit_nx     = tx_bit;
        tx_shift_nx   = tx_shift;
        hold_data_nx  = hold_data;
        hold_valid_nx = hold_valid;
        tx_serial_nx  = tx_serial;
        tx_busy_nx    = tx_busy;
        char_sent_nx  = 1'b0;

        if (load_rise && !tx_busy) begin
            hold_data_nx  = bus_out;
            hold_valid_nx = 1'b1;
        end

        case (tx_state)
            ST_IDLE: begin
                if (hold_valid && trans_en) begin
                    tx_state_nx   = ST_START;
                    tx_shift_nx   = hold_data;
                    hold_valid_nx = 1'b0;
                    tx_busy_nx    = 1'b1;
                    tx_serial_nx  = 1'b0;
                    tx_cnt_nx     = '0;
                end
            end
            ST_START: begin
                if (tx_cnt_last) begin
                    tx_state_nx  = ST_DATA;
                    tx_cnt_nx    = '0;
                    tx_bit_nx    = '0;
                    tx_serial_nx = tx_shift[0];
                    tx_shift_nx  = tx_shift >> 1;
                end else begin
                    tx_cnt_nx = tx_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_last) begin
                    tx_cnt_nx = '0;
                    if (tx_bit == BIT_LAST) begin
                        tx_state_nx  = ST_STOP;
                        tx_serial_nx = 1'b1;
                    end else begin
                        tx_bit_nx    = tx_bit + BIT_W'(1);
                        tx_serial_nx = tx_shift[0];
                        tx_shift_nx  = tx_shift >> 1;
                    end
                end else begin
                    tx_cnt_nx = tx_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // Registered pulse lands on the final stop-bit cycle.
                if (tx_cnt == CNT_PRE_LAST) begin
                    char_sent_nx = 1'b1;
                end
                if (tx_cnt_last) begin
                    tx_state_nx = ST_IDLE;
                    tx_cnt_nx   = '0;
                    tx_busy_nx  = 1'b0;
                end else begin
                    tx_cnt_nx = tx_cnt + CNT_W'(1);
                end
            end
            default: begin
                tx_state_nx = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------- RX
    xfer_state_e       rx_state, rx_state_nx;
    logic [CNT_W-1:0]  rx_cnt, rx_cnt_nx;
    logic [BIT_W-1:0]  rx_bit, rx_bit_nx;
    logic [DATA_W-1:0] rx_shift, rx_shift_nx;
    logic [DATA_W-1:0] bus_in_nx;
    logic              char_rec_nx, frame_err_nx;
    logic              rx_s1, rx_s2, rx_prev;
    logic              rx_fall;
    logic              rx_cnt_last;

    assign rx_fall     = rx_prev & ~rx_s2;
    assign rx_cnt_last = (rx_cnt == CNT_LAST);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rx_s1     <= 1'b1;
            rx_s2     <= 1'b1;
            rx_prev   <= 1'b1;
            rx_state  <= ST_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            bus_in    <= '0;
            char_rec  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_s1     <= rx_serial;
            rx_s2     <= rx_s1;
            rx_prev   <= rx_s2;
            rx_state  <= rx_state_nx;
            rx_cnt    <= rx_cnt_nx;
            rx_bit    <= rx_bit_nx;
            rx_shift  <= rx_shift_nx;
            bus_in    <= bus_in_nx;
            char_rec  <= char_rec_nx;
            frame_err <= frame_err_nx;
        end
    end

    // Samples land mid-bit: half a bit after the falling edge, then every full bit.
    always_comb begin
        rx_state_nx  = rx_state;
        rx_cnt_nx    = rx_cnt;
        rx_bit_nx    = rx_bit;
        rx_shift_nx  = rx_shift;
        bus_in_nx    = bus_in;
        char_rec_nx  = 1'b0;
        frame_err_nx = frame_err;

        case (rx_state)
            ST_IDLE: begin
                if (rx_fall) begin
                    rx_state_nx = ST_START;
                    rx_cnt_nx   = '0;
                end
            end
            ST_START: begin
                if (rx_cnt == CNT_HALF) begin
                    rx_cnt_nx   = '0;
                    rx_bit_nx   = '0;
                    rx_state_nx = rx_s2 ? ST_IDLE : ST_DATA;
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (rx_cnt_last) begin
                    rx_cnt_nx   = '0;
                    rx_shift_nx = {rx_s2, rx_shift[DATA_W-1:1]};
                    if (rx_bit == BIT_LAST) begin
                        rx_state_nx = ST_STOP;
                    end else begin
                        rx_bit_nx = rx_bit + BIT_W'(1);
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            ST_STOP: begin
                // A low line here stays low in IDLE, so a break cannot re-trigger.
                if (rx_cnt_last) begin
                    rx_cnt_nx   = '0;
                    rx_state_nx = ST_IDLE;
                    if (rx_s2) begin
                        bus_in_nx    = rx_shift;
                        char_rec_nx  = 1'b1;
                        frame_err_nx = 1'b0;
                    end else begin
                        frame_err_nx = 1'b1;
                    end
                end else begin
                    rx_cnt_nx = rx_cnt + CNT_W'(1);
                end
            end
            default: begin
                rx_state_nx = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_link_xcvr.sv
// Self-checking bench for serial_link_xcvr: directed + randomized 8N1 traffic
// checked against a frame-level model (bit lists, byte queues, sticky error flag).
module tb_serial_link_xcvr;

    localparam int unsigned CPB  = 4;
    localparam int unsigned CPB8 = 8;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] bus_out;
    logic       load, trans_en;
    logic       char_sent, tx_busy, tx_serial;
    logic       rx_drv, loopback, rx_serial;
    logic [7:0] bus_in;
    logic       char_rec, frame_err;

    logic       rx8;
    logic       char_sent8, tx_busy8, tx_serial8;
    logic [7:0] bus_in8;
    logic       char_rec8, frame_err8;

    assign rx_serial = loopback ? tx_serial : rx_drv;

    serial_link_xcvr #(.CLKS_PER_BIT(CPB), .DATA_W(8)) u_dut (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus_out       (bus_out),
        .load          (load),
        .trans_en      (trans_en),
        .char_sent     (char_sent),
        .tx_busy       (tx_busy),
        .tx_serial     (tx_serial),
        .rx_serial     (rx_serial),
        .bus_in        (bus_in),
        .char_rec      (char_rec),
        .frame_err     (frame_err)
    );

    serial_link_xcvr #(.CLKS_PER_BIT(CPB8), .DATA_W(8)) u_dut8 (
        .clk_clk       (clk),
        .reset_reset_n (rst_n),
        .bus_out       (8'h00),
        .load          (1'b0),
        .trans_en      (1'b0),
        .char_sent     (char_sent8),
        .tx_busy       (tx_busy8),
        .tx_serial     (tx_serial8),
        .rx_serial     (rx8),
        .bus_in        (bus_in8),
        .char_rec      (char_rec8),
        .frame_err     (frame_err8)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Event monitors: every cycle with char_rec high records bus_in.
    logic [7:0] rec_q[$];
    int         sent_cnt = 0;
    int         rec8_cnt = 0;
    always @(negedge clk) begin
        if (char_rec === 1'b1) rec_q.push_back(bus_in);
        if (char_sent === 1'b1) sent_cnt++;
        if (char_rec8 === 1'b1) rec8_cnt++;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    // Sends one byte (optionally pre-loaded) and checks every bit period of the frame.
    task automatic tx_frame(input logic [7:0] b, input bit do_load, input bit inject_ff,
                            input bit drop_en);
        logic [9:0] fr;
        bit         found;
        int         sent0;
        fr = {1'b1, b, 1'b0};
        if (do_load) begin
            bus_out = b;
            load    = 1'b1;
            @(negedge clk);
            load    = 1'b0;
        end
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) found = 1'b1;
        end
        check("tx_start_seen", 32'(found), 32'd1);
        if (!found) return;
        sent0 = sent_cnt;
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) @(negedge clk);
            check("tx_bit", 32'(tx_serial), 32'(fr[(k-1)/CPB]));
            check("tx_busy_in_frame", 32'(tx_busy), 32'd1);
            check("char_sent_timing", 32'(char_sent), 32'(k == 40));
            if (inject_ff && k == 10) begin bus_out = 8'hFF; load = 1'b1; end
            if (inject_ff && k == 11) load = 1'b0;
            if (drop_en && k == 6) trans_en = 1'b0;
        end
        @(negedge clk);
        check("tx_busy_after_frame", 32'(tx_busy), 32'd0);
        check("tx_line_after_frame", 32'(tx_serial), 32'd1);
        check("char_sent_count", 32'(sent_cnt - sent0), 32'd1);
        if (drop_en) trans_en = 1'b1;
    endtask

    // Drives one 8N1 frame onto the chosen RX input, followed by two idle bit times.
    task automatic rx_drive(input logic [7:0] b, input bit stop_ok, input bit to8, input int cpb);
        logic [9:0] fr;
        fr = {stop_ok, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            if (to8) rx8 = fr[i]; else rx_drv = fr[i];
            repeat (cpb) @(negedge clk);
        end
        if (to8) rx8 = 1'b1; else rx_drv = 1'b1;
        repeat (2 * cpb) @(negedge clk);
    endtask

    logic [7:0] exp_bus;
    logic       exp_ferr;
    int         exp_rec;
    int         base;
    int         bad_cycles;
    logic [7:0] got;
    logic [7:0] lb_bytes[8];
    logic [7:0] rb;
    bit         rok;
    bit         found_r;

    initial begin
        rst_n = 1'b0; bus_out = 8'h00; load = 1'b0; trans_en = 1'b0;
        rx_drv = 1'b1; loopback = 1'b0; rx8 = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx_serial", 32'(tx_serial), 32'd1);
        check("reset_tx_busy", 32'(tx_busy), 32'd0);
        check("reset_char_sent", 32'(char_sent), 32'd0);
        check("reset_bus_in", 32'(bus_in), 32'h00);
        check("reset_char_rec", 32'(char_rec), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed A5 frame.
        trans_en = 1'b1;
        tx_frame(8'hA5, 1'b1, 1'b0, 1'b0);

        // Loaded byte waits while trans_en is low.
        trans_en = 1'b0;
        bus_out = 8'h3C; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        bad_cycles = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad_cycles++;
        end
        check("gated_line_idle", 32'(bad_cycles), 32'd0);
        trans_en = 1'b1;
        base = sent_cnt;
        tx_frame(8'h3C, 1'b0, 1'b1, 1'b0);
        bad_cycles = 0;
        repeat (60) begin
            @(negedge clk);
            if (tx_serial !== 1'b1 || tx_busy !== 1'b0) bad_cycles++;
        end
        check("busy_load_ignored", 32'(bad_cycles), 32'd0);
        check("single_frame_sent", 32'(sent_cnt - base), 32'd1);

        // Random TX bytes, one with trans_en dropped mid-frame.
        for (int i = 0; i < 3; i++)
            tx_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, i == 1);

        // Loopback, back-to-back.
        loopback = 1'b1;
        repeat (4) @(negedge clk);
        lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h5A;
        for (int i = 3; i < 8; i++) lb_bytes[i] = 8'($urandom_range(0, 255));
        base = rec_q.size();
        for (int i = 0; i < 8; i++) tx_frame(lb_bytes[i], 1'b1, 1'b0, 1'b0);
        repeat (10) @(negedge clk);
        check("lb_rec_count", 32'(rec_q.size() - base), 32'd8);
        for (int i = 0; i < 8; i++) begin
            got = (base + i < rec_q.size()) ? rec_q[base + i] : 8'hxx;
            check("lb_data", 32'(got), 32'(lb_bytes[i]));
        end
        check("lb_bus_in", 32'(bus_in), 32'(lb_bytes[7]));
        check("lb_frame_err", 32'(frame_err), 32'd0);
        loopback = 1'b0;
        repeat (4) @(negedge clk);

        // Random RX frames against the byte/flag model.
        exp_bus = lb_bytes[7]; exp_ferr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            rb  = 8'($urandom_range(0, 255));
            rok = ($urandom_range(0, 2) != 0);
            base = rec_q.size();
            rx_drive(rb, rok, 1'b0, CPB);
            exp_rec = rok ? 1 : 0;
            if (rok) begin exp_bus = rb; exp_ferr = 1'b0; end
            else exp_ferr = 1'b1;
            check("rx_rand_rec_count", 32'(rec_q.size() - base), 32'(exp_rec));
            check("rx_rand_bus_in", 32'(bus_in), 32'(exp_bus));
            check("rx_rand_frame_err", 32'(frame_err), 32'(exp_ferr));
        end

        // Directed bad stop bit, then good frame.
        base = rec_q.size();
        rx_drive(8'h81, 1'b0, 1'b0, CPB);
        check("rx_bad_stop_err", 32'(frame_err), 32'd1);
        check("rx_bad_stop_no_rec", 32'(rec_q.size() - base), 32'd0);
        check("rx_bad_stop_bus_hold", 32'(bus_in), 32'(exp_bus));
        rx_drive(8'h42, 1'b1, 1'b0, CPB);
        check("rx_good_clears_err", 32'(frame_err), 32'd0);
        check("rx_good_bus_in", 32'(bus_in), 32'h42);
        check("rx_good_rec_count", 32'(rec_q.size() - base), 32'd1);

        // Glitch on the CLKS_PER_BIT=8 instance, then a real frame.
        base = rec8_cnt;
        rx8 = 1'b0;
        @(negedge clk);
        rx8 = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_no_rec", 32'(rec8_cnt - base), 32'd0);
        check("glitch_no_ferr", 32'(frame_err8), 32'd0);
        check("glitch_bus_in", 32'(bus_in8), 32'h00);
        rx_drive(8'hC3, 1'b1, 1'b1, CPB8);
        check("rx8_bus_in", 32'(bus_in8), 32'hC3);
        check("rx8_rec_count", 32'(rec8_cnt - base), 32'd1);
        check("rx8_frame_err", 32'(frame_err8), 32'd0);
        check("dut8_tx_idle", 32'({tx_serial8, tx_busy8, char_sent8}), 32'b100);

        // Reset asserted mid-frame.
        loopback = 1'b1; trans_en = 1'b1;
        bus_out = 8'h00; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        found_r = 1'b0;
        for (int i = 0; i < 20 && !found_r; i++) begin
            @(negedge clk);
            if (tx_serial === 1'b0) found_r = 1'b1;
        end
        check("rst_frame_started", 32'(found_r), 32'd1);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_serial", 32'(tx_serial), 32'd1);
        check("rst_mid_tx_busy", 32'(tx_busy), 32'd0);
        check("rst_mid_bus_in", 32'(bus_in), 32'h00);
        check("rst_mid_frame_err", 32'(frame_err), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = rec_q.size();
        bad_cycles = sent_cnt;
        repeat (80) @(negedge clk);
        check("rst_no_char_sent", 32'(sent_cnt - bad_cycles), 32'd0);
        check("rst_no_char_rec", 32'(rec_q.size() - base), 32'd0);
        check("rst_line_idle", 32'(tx_serial), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
